// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the ID-stage hazard and forwarding control.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_RF      = 2'd0,
    FWD_EXE     = 2'd1,
    FWD_MEM_ALU = 2'd2,
    FWD_MEM_LD  = 2'd3
  } fwd_e;

  typedef enum logic {
    RUN      = 1'b0,
    DIV_WAIT = 1'b1
  } div_state_e;

  localparam int CNT_W = 6;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Producer match and forward-select priority for one ID source operand.
module hazard_ctrl_fwd_sel
  import hazard_ctrl_pkg::*;
(
  input  logic       uses,
  input  logic [4:0] src,
  input  logic [4:0] exe_reg,
  input  logic       exe_wreg,
  input  logic       exe_is_load,
  input  logic [4:0] mem_reg,
  input  logic       mem_wreg,
  input  logic       mem_is_load,
  output fwd_e       fwd,
  output logic       exe_hit,
  output logic       mem_hit
);

  // $0 is hardwired, so it never matches a producer
  assign exe_hit = uses & exe_wreg & (exe_reg == src) & (src != 5'd0);
  assign mem_hit = uses & mem_wreg & (mem_reg == src) & (src != 5'd0);

  always_comb begin
    fwd = FWD_RF;
    if (exe_hit && !exe_is_load)
      fwd = FWD_EXE;
    else if (mem_hit)
      fwd = mem_is_load ? FWD_MEM_LD : FWD_MEM_ALU;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// ID-stage hazard control: operand forwarding, stalls, IF flush, HI/LO divide tracking.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       id_is_branch,
  input  logic       id_is_div,
  input  logic       id_uses_hilo,
  input  logic [4:0] exe_reg,
  input  logic [4:0] mem_reg,
  input  logic       exe_wreg,
  input  logic       mem_wreg,
  input  logic       exe_is_load,
  input  logic       mem_is_load,
  input  logic [1:0] pcsource,
  output logic [1:0] fwda,
  output logic [1:0] fwdb,
  output logic       stall_if,
  output logic       stall_id,
  output logic       bubble_ex,
  output logic       flush_if,
  output logic       div_start,
  output logic       div_busy
);

  fwd_e       sel_a;
  fwd_e       sel_b;
  logic       a_exe;
  logic       a_mem;
  logic       b_exe;
  logic       b_mem;
  logic       load_use;
  logic       br_haz;
  logic       hilo_haz;
  logic       hazard;
  div_state_e state;
  logic [CNT_W-1:0] cnt;

  hazard_ctrl_fwd_sel u_fwd_a (
    .uses        (id_uses_rs),
    .src         (id_rs),
    .exe_reg     (exe_reg),
    .exe_wreg    (exe_wreg),
    .exe_is_load (exe_is_load),
    .mem_reg     (mem_reg),
    .mem_wreg    (mem_wreg),
    .mem_is_load (mem_is_load),
    .fwd         (sel_a),
    .exe_hit     (a_exe),
    .mem_hit     (a_mem)
  );

  hazard_ctrl_fwd_sel u_fwd_b (
    .uses        (id_uses_rt),
    .src         (id_rt),
    .exe_reg     (exe_reg),
    .exe_wreg    (exe_wreg),
    .exe_is_load (exe_is_load),
    .mem_reg     (mem_reg),
    .mem_wreg    (mem_wreg),
    .mem_is_load (mem_is_load),
    .fwd         (sel_b),
    .exe_hit     (b_exe),
    .mem_hit     (b_mem)
  );

  assign fwda = sel_a;
  assign fwdb = sel_b;

  // Branch compares in ID, so any EXE result or a MEM load is too late
  assign load_use = id_valid & exe_is_load & (a_exe | b_exe);
  assign br_haz   = id_valid & id_is_branch &
                    (a_exe | b_exe | (mem_is_load & (a_mem | b_mem)));
  assign hilo_haz = id_valid & (id_uses_hilo | id_is_div) &
                    (state != RUN);
  assign hazard   = load_use | br_haz | hilo_haz;

  assign stall_if  = hazard;
  assign stall_id  = hazard;
  assign bubble_ex = hazard;
  assign flush_if  = id_valid & (pcsource != 2'd0) & ~hazard;

  assign div_start = ~reset & (state == RUN) & id_valid &
                     id_is_div & ~hazard;
  assign div_busy  = (state == DIV_WAIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      unique case (state)
        RUN: begin
          if (div_start) begin
            state <= DIV_WAIT;
            cnt   <= CNT_W'(DIV_CYCLES - 1);
          end
        end
        DIV_WAIT: begin
          if (cnt == '0)
            state <= RUN;
          else
            cnt <= cnt - 1'b1;
        end
        default: begin
          state <= RUN;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl with directed, hand-computed vectors.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rs;
  logic       id_uses_rt;
  logic       id_is_branch;
  logic       id_is_div;
  logic       id_uses_hilo;
  logic [4:0] exe_reg;
  logic [4:0] mem_reg;
  logic       exe_wreg;
  logic       mem_wreg;
  logic       exe_is_load;
  logic       mem_is_load;
  logic [1:0] pcsource;
  logic [1:0] fwda;
  logic [1:0] fwdb;
  logic       stall_if;
  logic       stall_id;
  logic       bubble_ex;
  logic       flush_if;
  logic       div_start;
  logic       div_busy;

  typedef struct {
    logic       rst;
    logic       vld;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic       br;
    logic       dv;
    logic       hl;
    logic [4:0] ereg;
    logic [4:0] mreg;
    logic       ew;
    logic       mw;
    logic       el;
    logic       ml;
    logic [1:0] pcs;
  } in_t;

  typedef struct {
    logic [1:0] fwda;
    logic [1:0] fwdb;
    logic       stall;
    logic       flush;
    logic       ds;
    logic       busy;
  } exp_t;

  exp_t  sq[$];
  string nq[$];
  int    checks = 0;
  int    errors = 0;

  hazard_ctrl #(.DIV_CYCLES(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rs   (id_uses_rs),
    .id_uses_rt   (id_uses_rt),
    .id_is_branch (id_is_branch),
    .id_is_div    (id_is_div),
    .id_uses_hilo (id_uses_hilo),
    .exe_reg      (exe_reg),
    .mem_reg      (mem_reg),
    .exe_wreg     (exe_wreg),
    .mem_wreg     (mem_wreg),
    .exe_is_load  (exe_is_load),
    .mem_is_load  (mem_is_load),
    .pcsource     (pcsource),
    .fwda         (fwda),
    .fwdb         (fwdb),
    .stall_if     (stall_if),
    .stall_id     (stall_id),
    .bubble_ex    (bubble_ex),
    .flush_if     (flush_if),
    .div_start    (div_start),
    .div_busy     (div_busy)
  );

  always #5 clk = ~clk;

  function automatic in_t idle();
    in_t v;
    v = '{rst: 1'b0, vld: 1'b0, rs: 5'd0, rt: 5'd0, urs: 1'b0,
          urt: 1'b0, br: 1'b0, dv: 1'b0, hl: 1'b0, ereg: 5'd0,
          mreg: 5'd0, ew: 1'b0, mw: 1'b0, el: 1'b0, ml: 1'b0,
          pcs: 2'd0};
    return v;
  endfunction

  function automatic exp_t ok();
    exp_t e;
    e = '{fwda: 2'd0, fwdb: 2'd0, stall: 1'b0, flush: 1'b0,
          ds: 1'b0, busy: 1'b0};
    return e;
  endfunction

  task automatic apply(input in_t v);
    reset        = v.rst;
    id_valid     = v.vld;
    id_rs        = v.rs;
    id_rt        = v.rt;
    id_uses_rs   = v.urs;
    id_uses_rt   = v.urt;
    id_is_branch = v.br;
    id_is_div    = v.dv;
    id_uses_hilo = v.hl;
    exe_reg      = v.ereg;
    mem_reg      = v.mreg;
    exe_wreg     = v.ew;
    mem_wreg     = v.mw;
    exe_is_load  = v.el;
    mem_is_load  = v.ml;
    pcsource     = v.pcs;
  endtask

  task automatic step(input string nm, input in_t v, input exp_t e);
    @(posedge clk);
    #1;
    apply(v);
    sq.push_back(e);
    nq.push_back(nm);
  endtask

  task automatic chk(input string nm, input string f,
                     input logic [1:0] got, input logic [1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s.%s got %0d expected %0d", nm, f, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (sq.size() != 0) begin
      exp_t  e;
      string n;
      e = sq.pop_front();
      n = nq.pop_front();
      chk(n, "fwda", fwda, e.fwda);
      chk(n, "fwdb", fwdb, e.fwdb);
      chk(n, "stall_if", {1'b0, stall_if}, {1'b0, e.stall});
      chk(n, "stall_id", {1'b0, stall_id}, {1'b0, e.stall});
      chk(n, "bubble_ex", {1'b0, bubble_ex}, {1'b0, e.stall});
      chk(n, "flush_if", {1'b0, flush_if}, {1'b0, e.flush});
      chk(n, "div_start", {1'b0, div_start}, {1'b0, e.ds});
      chk(n, "div_busy", {1'b0, div_busy}, {1'b0, e.busy});
    end
  end

  initial begin
    in_t  v;
    exp_t e;
    v = idle();
    v.rst = 1'b1;
    apply(v);

    // Reset state, combinational paths live during reset
    e = ok();
    step("rst_idle", v, e);
    v = idle(); v.rst = 1; v.vld = 1; v.dv = 1;
    v.rs = 5; v.urs = 1; v.ereg = 5; v.ew = 1;
    e = ok(); e.fwda = 1;
    step("rst_div_fwd", v, e);

    // Forwarding patterns
    v = idle(); v.vld = 1; v.rs = 5; v.urs = 1; v.ereg = 5; v.ew = 1;
    e = ok(); e.fwda = 1;
    step("exe_alu_rs", v, e);
    v = idle(); v.vld = 1; v.rs = 0; v.urs = 1; v.ereg = 0; v.ew = 1;
    e = ok();
    step("reg0", v, e);
    v = idle(); v.vld = 1; v.rt = 7; v.urt = 1; v.mreg = 7; v.mw = 1;
    e = ok(); e.fwdb = 2;
    step("mem_alu_rt", v, e);
    v = idle(); v.vld = 1; v.rs = 3; v.urs = 1;
    v.ereg = 3; v.ew = 1; v.mreg = 3; v.mw = 1; v.ml = 1;
    e = ok(); e.fwda = 1;
    step("exe_over_mem", v, e);
    v = idle(); v.vld = 1; v.rs = 3; v.urs = 0; v.ereg = 3; v.ew = 1;
    e = ok();
    step("rs_unused", v, e);
    v = idle(); v.vld = 1; v.rt = 6; v.urt = 1; v.ereg = 6; v.ew = 0;
    e = ok();
    step("exe_no_wreg", v, e);

    // Load-use: stall once, then forward load data from MEM
    v = idle(); v.vld = 1; v.rt = 8; v.urt = 1;
    v.ereg = 8; v.ew = 1; v.el = 1;
    e = ok(); e.stall = 1;
    step("lu_stall", v, e);
    v = idle(); v.vld = 1; v.rt = 8; v.urt = 1;
    v.mreg = 8; v.mw = 1; v.ml = 1;
    e = ok(); e.fwdb = 3;
    step("lu_fwd_ld", v, e);
    v = idle(); v.vld = 0; v.rt = 8; v.urt = 1;
    v.ereg = 8; v.ew = 1; v.el = 1;
    e = ok();
    step("lu_invalid", v, e);

    // Branch after load: two stalls, then resolve with redirect
    v = idle(); v.vld = 1; v.br = 1; v.rs = 9; v.urs = 1; v.pcs = 1;
    v.ereg = 9; v.ew = 1; v.el = 1;
    e = ok(); e.stall = 1;
    step("br_ld_exe", v, e);
    v = idle(); v.vld = 1; v.br = 1; v.rs = 9; v.urs = 1; v.pcs = 1;
    v.mreg = 9; v.mw = 1; v.ml = 1;
    e = ok(); e.stall = 1; e.fwda = 3;
    step("br_ld_mem", v, e);
    v = idle(); v.vld = 1; v.br = 1; v.rs = 9; v.urs = 1; v.pcs = 1;
    e = ok(); e.flush = 1;
    step("br_resolve_taken", v, e);
    v = idle(); v.vld = 1; v.br = 1; v.rs = 9; v.urs = 1; v.pcs = 0;
    e = ok();
    step("br_resolve_nt", v, e);
    v = idle(); v.vld = 1; v.br = 1; v.rt = 4; v.urt = 1; v.pcs = 2;
    v.ereg = 4; v.ew = 1;
    e = ok(); e.stall = 1; e.fwdb = 1;
    step("br_exe_alu", v, e);
    v = idle(); v.vld = 1; v.br = 1; v.rt = 4; v.urt = 1; v.pcs = 3;
    v.mreg = 4; v.mw = 1;
    e = ok(); e.fwdb = 2; e.flush = 1;
    step("br_mem_alu", v, e);
    v = idle(); v.vld = 0; v.pcs = 2;
    e = ok();
    step("flush_invalid", v, e);

    // Divide held back by a load-use hazard
    v = idle(); v.vld = 1; v.dv = 1; v.rs = 2; v.urs = 1;
    v.ereg = 2; v.ew = 1; v.el = 1;
    e = ok(); e.stall = 1;
    step("div_blocked", v, e);

    // Divide issue, mflo waits 32 cycles, issues on cycle 33
    v = idle(); v.vld = 1; v.dv = 1;
    e = ok(); e.ds = 1;
    step("div_issue", v, e);
    for (int k = 1; k <= 32; k++) begin
      v = idle(); v.vld = 1; v.hl = 1;
      if (k == 5) v.dv = 1;
      if (k == 10) begin
        v.rs = 2; v.urs = 1; v.ereg = 2; v.ew = 1; v.el = 1;
      end
      e = ok(); e.stall = 1; e.busy = 1;
      step($sformatf("div_wait%0d", k), v, e);
    end
    v = idle(); v.vld = 1; v.hl = 1;
    e = ok();
    step("mflo_issue", v, e);

    // Reset at counter value 10 abandons the divide
    v = idle(); v.vld = 1; v.dv = 1;
    e = ok(); e.ds = 1;
    step("div2_issue", v, e);
    for (int k = 1; k <= 21; k++) begin
      v = idle();
      e = ok(); e.busy = 1;
      step($sformatf("div2_wait%0d", k), v, e);
    end
    v = idle(); v.rst = 1;
    e = ok();
    step("div2_reset", v, e);
    v = idle(); v.vld = 1; v.hl = 1;
    e = ok();
    step("post_rst_mflo", v, e);
    v = idle();
    e = ok();
    step("post_rst_idle1", v, e);
    step("post_rst_idle2", v, e);

    for (int i = 0; i < 5 && sq.size() != 0; i++)
      @(negedge clk);
    #1;
    if (sq.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending expected 0", sq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
